stim_gen: RTL and testbench

Synthesisable, parametrised exhaustive-stimulus generator for gate-level and small combinational DUTs. It steps a WIDTH-bit vector through all 2^WIDTH codes, holding each code for HOLD_CYC clocks. It samples a 1-bit DUT response at the end of each hold and reports how many vectors produced a 1. It replaces free-running bench counters with a start/stop/pause-controlled block that is usable on silicon and in simulation.

---
 rtl/stim_gen_pkg.sv | 19 +
 rtl/stim_gen_timer.sv | 36 +++
 rtl/stim_gen.sv | 175 +++++++++++++++++
 tb/tb_stim_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_gen_pkg.sv
// stim_gen_pkg: shared types and helpers for the exhaustive-stimulus generator.
//   - state_e   : controller states (IDLE / RUN / DONE)
//   - MAX_WIDTH : upper bound on the stimulus vector width
//   - bin2gray  : binary to reflected-Gray conversion (MAX_WIDTH bits)
package stim_gen_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/stim_gen_timer.sv
// stim_gen_timer: hold counter for stim_gen. Counts 0..HOLD_CYC-1 while
// enabled, wraps to 0 after the terminal count, clears synchronously.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear to 0 (priority over enable)
//   i_en           : advance the counter this clock
//   o_term         : high on the enabled clock where the count is HOLD_CYC-1
module stim_gen_timer #(
    parameter int HOLD_CYC = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // Terminal pulse is qualified by enable so a paused clock never samples.
    assign o_term = i_en & (r_cnt == LAST);

endmodule

// File: rtl/stim_gen.sv
// stim_gen: exhaustive stimulus generator. Steps a WIDTH-bit vector through
// all 2^WIDTH codes, each held HOLD_CYC clocks, samples i_resp on the last
// clock of each hold and reports the number of 1 responses per full pass.
// Parameters: WIDTH (1..16), HOLD_CYC (>=1), WRAP (0 single pass, 1 continuous)
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : start pulse (IDLE only)     i_stop  : abort to IDLE
//   i_pause        : freeze sequence in RUN      i_gray  : Gray mode, latched at start
//   i_resp         : DUT response                o_vec   : stimulus vector
//   o_vld          : o_vec live and not paused   o_busy  : in RUN
//   o_done         : 1-clock end-of-pass pulse   o_ones  : 1-count of last full pass
// Build option: STIM_GEN_GRAY_EN compiles in the Gray converter; without it
// i_gray is ignored and the sequence is always binary.
module stim_gen
    import stim_gen_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int HOLD_CYC = 2,
    parameter int WRAP     = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_pause,
    input  logic             i_gray,
    input  logic             i_resp,
    output logic [WIDTH-1:0] o_vec,
    output logic             o_vld,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH:0]   o_ones
);

    localparam logic [WIDTH-1:0] LAST_IDX = {WIDTH{1'b1}};

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_idx, w_idx_nxt;
    logic [WIDTH:0]   r_acc, w_acc_nxt;
    logic [WIDTH:0]   r_ones, w_ones_nxt;
    logic [WIDTH-1:0] r_vec, w_vec_code;
    logic             r_vld, w_vld_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_vec_upd;
    logic             w_term;
    logic             w_tmr_en;
    logic             w_tmr_clr;
    logic [WIDTH:0]   w_acc_sum;

    // Stop wins over pause and completion, so it also blocks the timer.
    assign w_tmr_en  = (r_state == ST_RUN) & ~i_pause & ~i_stop;
    assign w_tmr_clr = (r_state != ST_RUN);

    stim_gen_timer #(.HOLD_CYC(HOLD_CYC)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_term  (w_term)
    );

    assign w_acc_sum = r_acc + {{WIDTH{1'b0}}, i_resp};

`ifdef STIM_GEN_GRAY_EN
    logic r_gray, w_gray_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_gray <= 1'b0;
        else          r_gray <= w_gray_nxt;
    end

    // Mode comes from i_gray on the start clock, otherwise from the latch.
    always_comb begin
        w_gray_nxt = r_gray;
        if (r_state == ST_IDLE && i_start && !i_stop)
            w_gray_nxt = i_gray;
    end

    assign w_vec_code = w_gray_nxt ? WIDTH'(bin2gray(MAX_WIDTH'(w_idx_nxt))) : w_idx_nxt;
`else
    logic w_unused_gray;
    assign w_unused_gray = i_gray;
    assign w_vec_code    = w_idx_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_ones_nxt  = r_ones;
        w_vld_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_vec_upd   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_vld_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_vec_upd   = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_pause) begin
                    w_busy_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_vld_nxt  = 1'b1;
                    if (w_term) begin
                        w_acc_nxt = w_acc_sum;
                        w_idx_nxt = r_idx + 1'b1;
                        w_vec_upd = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            // Index wraps to 0 here but o_vec keeps the last code.
                            w_state_nxt = ST_DONE;
                            w_ones_nxt  = w_acc_sum;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_vld_nxt   = 1'b0;
                            w_vec_upd   = 1'b0;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (i_stop || WRAP == 0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_vld_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_vec_upd   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_ones  <= '0;
            r_vec   <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_ones  <= w_ones_nxt;
            r_vld   <= w_vld_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_vec_upd) r_vec <= w_vec_code;
        end
    end

    assign o_vec  = r_vec;
    assign o_vld  = r_vld;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_ones = r_ones;

endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: scoreboard bench for stim_gen (WIDTH=3, HOLD_CYC=2).
// Instance dut runs single passes (WRAP=0); dut_w runs continuous passes (WRAP=1).
module tb_stim_gen;
    localparam int W = 3;
    localparam int H = 2;
`ifdef STIM_GEN_GRAY_EN
    localparam bit GRAY_ON = 1'b1;
`else
    localparam bit GRAY_ON = 1'b0;
`endif

    typedef struct {
        int ones;
        int lat;
        int paused;
    } done_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, pause = 1'b0, gray = 1'b0;
    logic [1:0] resp_mode = 2'd0;
    logic resp;
    logic start_w = 1'b0, stop_w = 1'b0, resp_sel_w = 1'b0;
    logic resp_w;

    logic [W-1:0] vec, vec_w;
    logic         vld, busy, done, vld_w, busy_w, done_w;
    logic [W:0]   ones, ones_w;

    int exp_vec[$];
    int exp_vec_w[$];
    done_t exp_done[$];
    done_t exp_done_w[$];
    int nchk = 0, nerr = 0;
    int cyc = 0;
    int start_cyc = 0, start_cyc_w = 0;
    int last_done_w = -1;
    int pcnt = 0;
    int last_vec = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response modes: 0 = o_vec[0], 1 = constant 1, 2 = constant 0.
    assign resp   = (resp_mode == 2'd0) ? vec[0] : (resp_mode == 2'd1);
    assign resp_w = resp_sel_w ? (vec_w[1] & vec_w[0]) : vec_w[0];

    stim_gen #(.WIDTH(W), .HOLD_CYC(H), .WRAP(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_pause(pause), .i_gray(gray), .i_resp(resp),
        .o_vec(vec), .o_vld(vld), .o_busy(busy), .o_done(done), .o_ones(ones)
    );

    stim_gen #(.WIDTH(W), .HOLD_CYC(H), .WRAP(1)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w), .i_stop(stop_w),
        .i_pause(pause), .i_gray(gray), .i_resp(resp_w),
        .o_vec(vec_w), .o_vld(vld_w), .o_busy(busy_w), .o_done(done_w), .o_ones(ones_w)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_pass(input bit g);
        for (int c = 0; c < (1 << W); c++) begin
            int v;
            v = g ? (c ^ (c >> 1)) : c;
            for (int h = 0; h < H; h++) exp_vec.push_back(v);
        end
    endtask

    task automatic push_done(input int o, input int l, input int p);
        done_t d;
        d.ones = o; d.lat = l; d.paused = p;
        exp_done.push_back(d);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sig(input string name, input int budget, input bit use_w);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = use_w ? done_w : done;
        end
        if (!seen) begin
            nchk++; nerr++;
            $display("FAIL %s: no o_done within %0d clocks", name, budget);
        end
    endtask

    // Monitor: pops expected vectors / pass results whenever the DUT presents them.
    always @(negedge clk) begin : mon
        done_t d;
        int lat;
        if (rst_n) begin
            if (vld) begin
                if (exp_vec.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL vec_unexpected: got %0d with no vector expected", vec);
                end else chk("vec", vec, exp_vec.pop_front());
                last_vec = vec;
            end else if (busy) begin
                pcnt++;
                chk("pause_hold", vec, last_vec);
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL done_unexpected: got o_done with ones=%0d", ones);
                end else begin
                    d = exp_done.pop_front();
                    chk("ones", ones, d.ones);
                    chk("done_latency", cyc - start_cyc, d.lat);
                    chk("paused_clocks", pcnt, d.paused);
                    chk("busy_at_done", busy, 0);
                end
                pcnt = 0;
            end
            if (vld_w) begin
                if (exp_vec_w.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL vec_w_unexpected: got %0d with no vector expected", vec_w);
                end else chk("vec_w", vec_w, exp_vec_w.pop_front());
            end
            if (done_w) begin
                if (exp_done_w.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL done_w_unexpected: got o_done with ones=%0d", ones_w);
                end else begin
                    d = exp_done_w.pop_front();
                    lat = (last_done_w < 0) ? cyc - start_cyc_w : cyc - last_done_w;
                    chk("ones_w", ones_w, d.ones);
                    chk("done_w_spacing", lat, d.lat);
                    chk("vld_w_at_done", vld_w, 0);
                end
                last_done_w = cyc;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit seen;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_vec", vec, 0);
        chk("rst_vld", vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ones", ones, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pass A: resp = o_vec[0] -> 4 ones
        resp_mode = 2'd0;
        push_pass(1'b0);
        push_done(4, 17, 0);
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        wait_sig("passA", 40, 1'b0);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("ones_hold_idle", ones, 4);

        // Pass B: resp tied 1 -> 8 ones; a mid-run start must be ignored
        resp_mode = 2'd1;
        push_pass(1'b0);
        push_done(8, 17, 0);
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sig("passB", 40, 1'b0);

        // Pause for 3 clocks while o_vec = 2
        resp_mode = 2'd0;
        push_pass(1'b0);
        push_done(4, 20, 3);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = vld && (vec == 3'd2);
        end
        chk("saw_vec2", seen, 1);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        pause = 1'b0;
        wait_sig("pause_pass", 40, 1'b0);

        // Stop while o_vec = 5: no done, o_ones keeps 4
        for (int c = 0; c < 5; c++) begin
            exp_vec.push_back(c);
            exp_vec.push_back(c);
        end
        exp_vec.push_back(5);
        resp_mode = 2'd1;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = vld && (vec == 3'd5);
        end
        chk("saw_vec5", seen, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_vld", vld, 0);
        chk("stop_done", done, 0);
        chk("stop_ones_kept", ones, 4);
        chk("stop_queue_drained", exp_vec.size(), 0);
        repeat (3) @(negedge clk);
        chk("stop_still_idle", busy, 0);

        // start + stop together in IDLE: stays idle
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_vld", vld, 0);
        @(negedge clk);
        chk("startstop_busy2", busy, 0);

        // Gray request, latched at start then released
        resp_mode = 2'd0;
        gray = 1'b1;
        push_pass(GRAY_ON);
        push_done(4, 17, 0);
        pulse_start();
        gray = 1'b0;
        wait_sig("gray_pass", 40, 1'b0);

        // Reset mid-run aborts immediately
        resp_mode = 2'd1;
        push_pass(1'b0);
        pulse_start();
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vec", vec, 0);
        chk("midrst_vld", vld, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ones", ones, 0);
        exp_vec.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // WRAP=1: two passes 17 clocks apart, ones recomputed (4 then 2)
        resp_sel_w = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < (1 << W); c++)
                for (int h = 0; h < H; h++) exp_vec_w.push_back(c);
        begin
            done_t d;
            d.ones = 4; d.lat = 17; d.paused = 0;
            exp_done_w.push_back(d);
            d.ones = 2;
            exp_done_w.push_back(d);
        end
        @(negedge clk);
        start_cyc_w = cyc;
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        wait_sig("wrap_pass1", 40, 1'b1);
        resp_sel_w = 1'b1;
        wait_sig("wrap_pass2", 40, 1'b1);
        stop_w = 1'b1;
        @(negedge clk);
        stop_w = 1'b0;
        chk("wrap_stop_busy", busy_w, 0);
        chk("wrap_stop_vld", vld_w, 0);
        chk("wrap_ones_kept", ones_w, 2);

        repeat (3) @(negedge clk);
        chk("vec_q_left", exp_vec.size(), 0);
        chk("done_q_left", exp_done.size(), 0);
        chk("vec_w_q_left", exp_vec_w.size(), 0);
        chk("done_w_q_left", exp_done_w.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
